// File: rtl/svga_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// svga_pkg : default 800x600@72 timing, coordinate widths, sync helpers. Rev 1.0
// ----------------------------------------------------------------------------
package svga_pkg;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FRONT  = 56;
  localparam int DEF_H_SYNC   = 120;
  localparam int DEF_H_BACK   = 64;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FRONT  = 37;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BACK   = 23;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  // One display-stream sample; travels as a unit through the lead pipeline.
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           valid;
    logic           hsync;
    logic           vsync;
    logic           line_start;
    logic           frame_start;
  } disp_t;

  function automatic int sync_start(input int active, input int front);
    return active + front;
  endfunction

  function automatic int sync_end(input int active, input int front, input int width);
    return active + front + width - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/svga_timing_gen_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// svga_timing_gen_if : fetch and display streams of the raster generator. Rev 1.0
// ----------------------------------------------------------------------------
interface svga_timing_gen_if;
  import svga_pkg::*;

  logic [X_W-1:0] fetch_x;
  logic [Y_W-1:0] fetch_y;
  logic           fetch_valid;
  logic [X_W-1:0] pixel_x;
  logic [Y_W-1:0] pixel_y;
  logic           video_enable;
  logic           hsync;
  logic           vsync;
  logic           line_start;
  logic           frame_start;
  logic [7:0]     frame_count;

  modport master (
    output fetch_x, fetch_y, fetch_valid, pixel_x, pixel_y, video_enable,
           hsync, vsync, line_start, frame_start, frame_count
  );

  modport slave (
    input  fetch_x, fetch_y, fetch_valid, pixel_x, pixel_y, video_enable,
           hsync, vsync, line_start, frame_start, frame_count
  );

endinterface
`default_nettype wire

// File: rtl/svga_timing_gen_pipe_delay.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_delay : WIDTH x DEPTH shift register, sync active-low reset. Rev 1.0
// ----------------------------------------------------------------------------
module pipe_delay #(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Stage 0 in the low bits, oldest stage in the high bits.
  logic [WIDTH*DEPTH-1:0] r_sr;
  logic [WIDTH*DEPTH-1:0] w_next;

  generate
    if (DEPTH == 1) begin : g_single
      assign w_next = d;
    end else begin : g_chain
      assign w_next = {r_sr[WIDTH*(DEPTH-1)-1:0], d};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sr <= {DEPTH{RESET_VALUE}};
    end else begin
      r_sr <= w_next;
    end
  end

  assign q = r_sr[WIDTH*DEPTH-1 -: WIDTH];

endmodule
`default_nettype wire

// File: rtl/svga_timing_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// svga_timing_gen : free-running raster timing with early fetch stream. Rev 1.0
// ----------------------------------------------------------------------------
module svga_timing_gen
  import svga_pkg::*;
#(
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   H_FRONT   = DEF_H_FRONT,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BACK    = DEF_H_BACK,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   V_FRONT   = DEF_V_FRONT,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BACK    = DEF_V_BACK,
  parameter int   LEAD      = 2,
  parameter logic HSYNC_POL = 1'b1,
  parameter logic VSYNC_POL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  svga_timing_gen_if.master vid
);

  localparam int C_H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int C_V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [X_W-1:0] C_H_LAST   = X_W'(C_H_TOTAL - 1);
  localparam logic [X_W-1:0] C_H_ACT    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] C_HS_START = X_W'(sync_start(H_ACTIVE, H_FRONT));
  localparam logic [X_W-1:0] C_HS_END   = X_W'(sync_end(H_ACTIVE, H_FRONT, H_SYNC));
  localparam logic [Y_W-1:0] C_V_LAST   = Y_W'(C_V_TOTAL - 1);
  localparam logic [Y_W-1:0] C_V_ACT    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] C_VS_START = Y_W'(sync_start(V_ACTIVE, V_FRONT));
  localparam logic [Y_W-1:0] C_VS_END   = Y_W'(sync_end(V_ACTIVE, V_FRONT, V_SYNC));

  localparam disp_t C_RST = '{
    x:           '0,
    y:           '0,
    valid:       1'b0,
    hsync:       ~HSYNC_POL,
    vsync:       ~VSYNC_POL,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  generate
    if (C_H_TOTAL > 2048 || C_V_TOTAL > 1024 || LEAD < 1 || LEAD > 4) begin : g_bad_params
      $error("svga_timing_gen: totals exceed counter width or LEAD outside 1..4");
    end
  endgenerate

  logic [X_W-1:0] r_h;
  logic [Y_W-1:0] r_v;
  disp_t          r_fetch;
  disp_t          w_disp;
  logic [7:0]     r_frame_count;
  logic           w_h_wrap;

  assign w_h_wrap = (r_h == C_H_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_h <= w_h_wrap ? '0 : r_h + 1'b1;
      if (w_h_wrap) begin
        r_v <= (r_v == C_V_LAST) ? '0 : r_v + 1'b1;
      end
    end
  end

  // Every decode is made here so the whole bundle shares one latency.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch <= C_RST;
    end else begin
      r_fetch.x           <= r_h;
      r_fetch.y           <= r_v;
      r_fetch.valid       <= (r_h < C_H_ACT) && (r_v < C_V_ACT);
      r_fetch.hsync       <= (r_h >= C_HS_START && r_h <= C_HS_END) ? HSYNC_POL : ~HSYNC_POL;
      r_fetch.vsync       <= (r_v >= C_VS_START && r_v <= C_VS_END) ? VSYNC_POL : ~VSYNC_POL;
      r_fetch.line_start  <= (r_h == '0);
      r_fetch.frame_start <= (r_h == '0) && (r_v == '0);
    end
  end

  pipe_delay #(
    .WIDTH       ($bits(disp_t)),
    .DEPTH       (LEAD),
    .RESET_VALUE (C_RST)
  ) u_disp_pipe (
    .clk   (clk),
    .reset (reset),
    .d     (r_fetch),
    .q     (w_disp)
  );

  // The last displayed position of a frame is always followed by (0,0).
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_frame_count <= '0;
    end else if (w_disp.x == C_H_LAST && w_disp.y == C_V_LAST) begin
      r_frame_count <= r_frame_count + 1'b1;
    end
  end

  assign vid.fetch_x      = r_fetch.x;
  assign vid.fetch_y      = r_fetch.y;
  assign vid.fetch_valid  = r_fetch.valid;
  assign vid.pixel_x      = w_disp.x;
  assign vid.pixel_y      = w_disp.y;
  assign vid.video_enable = w_disp.valid;
  assign vid.hsync        = w_disp.hsync;
  assign vid.vsync        = w_disp.vsync;
  assign vid.line_start   = w_disp.line_start;
  assign vid.frame_start  = w_disp.frame_start;
  assign vid.frame_count  = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_svga_timing_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_svga_timing_gen : arithmetic raster model vs four generator configs. Rev 1.0
// ----------------------------------------------------------------------------
module tb_svga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, lead;
    bit hpol, vpol;
  } cfg_t;

  typedef struct {
    longint fx, fy, fv, px, py, ve, hs, vs, ls, fs, fc;
  } exp_t;

  cfg_t cfg_def = '{ha:800, hf:56, hs:120, hb:64, va:600, vf:37, vs:6, vb:23, lead:2, hpol:1'b1, vpol:1'b1};
  cfg_t cfg_s2  = '{ha:8, hf:2, hs:3, hb:2, va:4, vf:1, vs:2, vb:1, lead:2, hpol:1'b1, vpol:1'b1};
  cfg_t cfg_s1  = '{ha:8, hf:2, hs:3, hb:2, va:4, vf:1, vs:2, vb:1, lead:1, hpol:1'b1, vpol:1'b1};
  cfg_t cfg_s4  = '{ha:8, hf:2, hs:3, hb:2, va:4, vf:1, vs:2, vb:1, lead:4, hpol:1'b0, vpol:1'b0};

  logic   clk = 1'b0;
  logic   reset;
  logic   armed = 1'b0;
  longint k = 0;
  int     n_vec = 0;
  int     n_err = 0;

  always #5 clk = ~clk;

  svga_timing_gen_if vif_def ();
  svga_timing_gen_if vif_s2 ();
  svga_timing_gen_if vif_s1 ();
  svga_timing_gen_if vif_s4 ();

  svga_timing_gen #(.LEAD(2)) dut_def (.clk(clk), .reset(reset), .vid(vif_def));

  svga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .LEAD(2), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_s2 (.clk(clk), .reset(reset), .vid(vif_s2));

  svga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .LEAD(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_s1 (.clk(clk), .reset(reset), .vid(vif_s1));

  svga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .LEAD(4), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_s4 (.clk(clk), .reset(reset), .vid(vif_s4));

  // k = number of edges since the last reset edge (0 on the reset edge itself).
  always @(posedge clk) begin
    if (!reset) begin
      k     <= 0;
      armed <= 1'b1;
    end else begin
      k <= k + 1;
    end
  end

  // Fetch at edge k shows raster position k-1; display shows position k-1-LEAD.
  function automatic exp_t model(input cfg_t c, input longint kk);
    exp_t   e;
    longint ht, vt, p, q;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    e = '{default: 0};
    e.hs = c.hpol ? 0 : 1;
    e.vs = c.vpol ? 0 : 1;
    if (kk >= 1) begin
      p    = kk - 1;
      e.fx = p % ht;
      e.fy = (p / ht) % vt;
      e.fv = (e.fx < c.ha && e.fy < c.va) ? 1 : 0;
    end
    if (kk >= c.lead + 1) begin
      q    = kk - 1 - c.lead;
      e.px = q % ht;
      e.py = (q / ht) % vt;
      e.ve = (e.px < c.ha && e.py < c.va) ? 1 : 0;
      e.hs = (e.px >= c.ha + c.hf && e.px < c.ha + c.hf + c.hs) ? c.hpol : !c.hpol;
      e.vs = (e.py >= c.va + c.vf && e.py < c.va + c.vf + c.vs) ? c.vpol : !c.vpol;
      e.ls = (e.px == 0) ? 1 : 0;
      e.fs = (e.px == 0 && e.py == 0) ? 1 : 0;
      e.fc = (q / (ht * vt)) % 256;
    end
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint want);
    n_vec++;
    if (act != want) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s at k=%0d: got %0d, expected %0d", name, k, act, want);
    end
  endtask

  task automatic check_dut(input string tag, input cfg_t c, input longint kk,
                           input logic [10:0] fx, input logic [9:0] fy, input logic fv,
                           input logic [10:0] px, input logic [9:0] py,
                           input logic ve, input logic hs, input logic vs,
                           input logic ls, input logic fs, input logic [7:0] fc);
    exp_t e;
    e = model(c, kk);
    chk({tag, ".fetch_x"},      longint'(fx), e.fx);
    chk({tag, ".fetch_y"},      longint'(fy), e.fy);
    chk({tag, ".fetch_valid"},  longint'(fv), e.fv);
    chk({tag, ".pixel_x"},      longint'(px), e.px);
    chk({tag, ".pixel_y"},      longint'(py), e.py);
    chk({tag, ".video_enable"}, longint'(ve), e.ve);
    chk({tag, ".hsync"},        longint'(hs), e.hs);
    chk({tag, ".vsync"},        longint'(vs), e.vs);
    chk({tag, ".line_start"},   longint'(ls), e.ls);
    chk({tag, ".frame_start"},  longint'(fs), e.fs);
    chk({tag, ".frame_count"},  longint'(fc), e.fc);
  endtask

  task automatic run_track(input string name, input logic sig, input bit active,
                           input int want, inout bit on, inout int len);
    if (!active) begin
      on  = 1'b0;
      len = 0;
    end else if (sig) begin
      if (!on) begin
        on  = 1'b1;
        len = 0;
      end
      len++;
    end else if (on) begin
      chk(name, len, want);
      on = 1'b0;
    end
  endtask

  bit     hs_on_def, hs_on_s2, vs_on_s2;
  int     hs_len_def, hs_len_s2, vs_len_s2;
  longint last_fs;
  int     ve_cnt, ls_cnt;

  always @(negedge clk) begin
    if (armed) begin
      check_dut("def", cfg_def, k, vif_def.fetch_x, vif_def.fetch_y, vif_def.fetch_valid,
                vif_def.pixel_x, vif_def.pixel_y, vif_def.video_enable, vif_def.hsync,
                vif_def.vsync, vif_def.line_start, vif_def.frame_start, vif_def.frame_count);
      check_dut("s2", cfg_s2, k, vif_s2.fetch_x, vif_s2.fetch_y, vif_s2.fetch_valid,
                vif_s2.pixel_x, vif_s2.pixel_y, vif_s2.video_enable, vif_s2.hsync,
                vif_s2.vsync, vif_s2.line_start, vif_s2.frame_start, vif_s2.frame_count);
      check_dut("s1", cfg_s1, k, vif_s1.fetch_x, vif_s1.fetch_y, vif_s1.fetch_valid,
                vif_s1.pixel_x, vif_s1.pixel_y, vif_s1.video_enable, vif_s1.hsync,
                vif_s1.vsync, vif_s1.line_start, vif_s1.frame_start, vif_s1.frame_count);
      check_dut("s4", cfg_s4, k, vif_s4.fetch_x, vif_s4.fetch_y, vif_s4.fetch_valid,
                vif_s4.pixel_x, vif_s4.pixel_y, vif_s4.video_enable, vif_s4.hsync,
                vif_s4.vsync, vif_s4.line_start, vif_s4.frame_start, vif_s4.frame_count);

      // Hand-computed anchors for the 800x600 configuration, LEAD=2.
      case (k)
        0: begin
          chk("lit.rst_hsync", longint'(vif_def.hsync), 0);
          chk("lit.rst_frame_count", longint'(vif_def.frame_count), 0);
        end
        1: begin
          chk("lit.e1_fetch_x", longint'(vif_def.fetch_x), 0);
          chk("lit.e1_fetch_valid", longint'(vif_def.fetch_valid), 1);
          chk("lit.e1_video_enable", longint'(vif_def.video_enable), 0);
        end
        2: begin
          chk("lit.e2_video_enable", longint'(vif_def.video_enable), 0);
          chk("lit.e2_hsync", longint'(vif_def.hsync), 0);
          chk("lit.e2_frame_start", longint'(vif_def.frame_start), 0);
        end
        3: begin
          chk("lit.e3_pixel_x", longint'(vif_def.pixel_x), 0);
          chk("lit.e3_video_enable", longint'(vif_def.video_enable), 1);
          chk("lit.e3_frame_start", longint'(vif_def.frame_start), 1);
          chk("lit.e3_line_start", longint'(vif_def.line_start), 1);
        end
        802:  chk("lit.ve_at_799", longint'(vif_def.video_enable), 1);
        803:  chk("lit.ve_at_800", longint'(vif_def.video_enable), 0);
        858:  chk("lit.hsync_at_855", longint'(vif_def.hsync), 0);
        859:  chk("lit.hsync_at_856", longint'(vif_def.hsync), 1);
        978:  chk("lit.hsync_at_975", longint'(vif_def.hsync), 1);
        979:  chk("lit.hsync_at_976", longint'(vif_def.hsync), 0);
        1040: chk("lit.fetch_x_1039", longint'(vif_def.fetch_x), 1039);
        1041: begin
          chk("lit.wrap_fetch_x", longint'(vif_def.fetch_x), 0);
          chk("lit.wrap_fetch_y", longint'(vif_def.fetch_y), 1);
        end
        2483: begin
          chk("lit.pre_reset_pixel_x", longint'(vif_def.pixel_x), 400);
          chk("lit.pre_reset_pixel_y", longint'(vif_def.pixel_y), 2);
        end
        default: ;
      endcase

      // Anchors for the 15x8 configuration (120-clock frame), LEAD=2.
      case (k)
        123:   chk("lit.s2_count_1", longint'(vif_s2.frame_count), 1);
        243:   chk("lit.s2_count_2", longint'(vif_s2.frame_count), 2);
        30603: chk("lit.s2_count_255", longint'(vif_s2.frame_count), 255);
        30723: begin
          chk("lit.s2_count_wrap", longint'(vif_s2.frame_count), 0);
          chk("lit.s2_wrap_frame_start", longint'(vif_s2.frame_start), 1);
        end
        default: ;
      endcase

      run_track("def.hsync_width", vif_def.hsync, k > 2, 120, hs_on_def, hs_len_def);
      run_track("s2.hsync_width", vif_s2.hsync, k > 2, 3, hs_on_s2, hs_len_s2);
      run_track("s2.vsync_width", vif_s2.vsync, k > 2, 30, vs_on_s2, vs_len_s2);

      if (k <= 2) begin
        last_fs = 0;
        ve_cnt  = 0;
        ls_cnt  = 0;
      end else begin
        if (vif_s2.frame_start) begin
          if (last_fs != 0) begin
            chk("s2.frame_period", k - last_fs, 120);
            chk("s2.ve_per_frame", ve_cnt, 32);
            chk("s2.lines_per_frame", ls_cnt, 8);
          end
          last_fs = k;
          ve_cnt  = 0;
          ls_cnt  = 0;
        end
        ve_cnt += int'(vif_s2.video_enable);
        ls_cnt += int'(vif_s2.line_start);
      end
    end
  end

  task automatic wait_k(input longint target);
    int i;
    i = 0;
    while (k != target && i < 40000) begin
      @(negedge clk);
      i++;
    end
    if (k != target) chk("wait_timeout", k, target);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    // One-cycle reset while the 800x600 display sits at (400,2).
    wait_k(2483);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wait_k(30730);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
